preset_store: RTL and testbench

PRESET_STORE -- requirements
Module: preset_store

---
 rtl/midi_pkg.sv | 26 ++
 rtl/preset_store_if.sv | 23 ++
 rtl/bus_xfer.sv | 93 +++++++++
 rtl/preset_store.sv | 205 ++++++++++++++++++++
 tb/tb_preset_store.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/midi_pkg.sv
// Constants and FSM encoding shared by the preset flash store and its bus engine.
package midi_pkg;

    localparam logic [23:0] BASE_ADDR_DEF = 24'h1ffd80;
    localparam int unsigned PRESET_CNT    = 4;
    localparam logic [1:0]  LAST_IDX      = 2'(PRESET_CNT - 1);
    localparam logic [31:0] ERASED_WORD   = 32'hFFFF_FFFF;
    localparam logic [23:0] SECTOR_MASK   = 24'hFFF000;

    typedef enum logic [3:0] {
        LOAD_REQ,
        LOAD_WAIT,
        IDLE,
        SNAP,
        ERASE_REQ,
        ERASE_WAIT,
        WR_REQ,
        WR_WAIT,
        FAIL
    } state_e;

    function automatic logic [23:0] word_addr(input logic [23:0] base, input logic [1:0] idx);
        return base + {20'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/preset_store_if.sv
// Strobe/ack bus between the preset store (master) and the SPI flash controller (slave).
interface preset_store_if;

    logic [23:0] adr_o;
    logic [31:0] dat_o;
    logic        we_o;
    logic        stb_o;
    logic        erase_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        rty_i;

    modport master (
        output adr_o, dat_o, we_o, stb_o, erase_o,
        input  dat_i, ack_i, rty_i
    );

    modport slave (
        input  adr_o, dat_o, we_o, stb_o, erase_o,
        output dat_i, ack_i, rty_i
    );

endinterface

// File: rtl/bus_xfer.sv
// Single strobe/ack transfer engine: holds the request stable until a response and
// counts consecutive retries, flagging exhaustion at RETRY_MAX.
module bus_xfer
    import midi_pkg::*;
#(
    parameter int unsigned RETRY_MAX = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [23:0]   adr_i,
    input  logic [31:0]   wdat_i,
    input  logic          we_i,
    input  logic          erase_i,
    output logic          done_o,
    output logic          retry_o,
    output logic          fail_o,
    output logic [31:0]   rdat_o,
    preset_store_if.master bus
);

    localparam logic [3:0] RMAX = 4'(RETRY_MAX);

    logic        stb_q, stb_d;
    logic [23:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic        erase_q, erase_d;
    logic [2:0]  rcnt_q, rcnt_d;

    logic        resp_ack;
    logic        resp_rty;
    logic [3:0]  rcnt_inc;
    logic        exhaust;

    // A simultaneous ack and rty is taken as an ack.
    assign resp_ack = stb_q & bus.ack_i;
    assign resp_rty = stb_q & bus.rty_i & ~bus.ack_i;
    assign rcnt_inc = {1'b0, rcnt_q} + 4'd1;
    assign exhaust  = (rcnt_inc >= RMAX);

    assign done_o  = resp_ack;
    assign retry_o = resp_rty & ~exhaust;
    assign fail_o  = resp_rty & exhaust;
    assign rdat_o  = bus.dat_i;

    always_comb begin
        stb_d   = stb_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        erase_d = erase_q;
        rcnt_d  = rcnt_q;
        if (start_i) begin
            stb_d   = 1'b1;
            adr_d   = adr_i;
            dat_d   = wdat_i;
            we_d    = we_i;
            erase_d = erase_i;
        end else if (resp_ack) begin
            stb_d  = 1'b0;
            rcnt_d = '0;
        end else if (resp_rty) begin
            stb_d  = 1'b0;
            rcnt_d = exhaust ? 3'd0 : rcnt_inc[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            erase_q <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            erase_q <= erase_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign bus.stb_o   = stb_q;
    assign bus.adr_o   = adr_q;
    assign bus.dat_o   = dat_q;
    assign bus.we_o    = we_q;
    assign bus.erase_o = erase_q;

endmodule

// File: rtl/preset_store.sv
// Loads the four preset words from flash after reset and, on request, snapshots the
// live preset table and rewrites it to flash (sector erase followed by four writes).
module preset_store
    import midi_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned RETRY_MAX = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          save_req,
    output logic [1:0]    rd_idx,
    input  logic [31:0]   rd_data,
    output logic          pw_valid,
    output logic [1:0]    pw_idx,
    output logic [31:0]   pw_data,
    output logic [3:0]    loaded,
    output logic          busy,
    output logic          err,
    preset_store_if.master bus
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
    logic [3:0]  loaded_q, loaded_d;
    logic        pw_valid_q, pw_valid_d;
    logic [1:0]  pw_idx_q, pw_idx_d;
    logic [31:0] pw_data_q, pw_data_d;
    logic [31:0] preset_buf_q [PRESET_CNT];
    logic [31:0] preset_buf_d [PRESET_CNT];

    logic        xf_start;
    logic [23:0] xf_adr;
    logic [31:0] xf_wdat;
    logic        xf_we;
    logic        xf_erase;
    logic        xf_done;
    logic        xf_retry;
    logic        xf_fail;
    logic [31:0] xf_rdat;

    bus_xfer #(
        .RETRY_MAX (RETRY_MAX)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .start_i (xf_start),
        .adr_i   (xf_adr),
        .wdat_i  (xf_wdat),
        .we_i    (xf_we),
        .erase_i (xf_erase),
        .done_o  (xf_done),
        .retry_o (xf_retry),
        .fail_o  (xf_fail),
        .rdat_o  (xf_rdat),
        .bus     (bus)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        err_d        = err_q;
        loaded_d     = loaded_q;
        pw_valid_d   = 1'b0;
        pw_idx_d     = pw_idx_q;
        pw_data_d    = pw_data_q;
        preset_buf_d = preset_buf_q;
        xf_start     = 1'b0;
        xf_adr       = word_addr(BASE_ADDR, idx_q);
        xf_wdat      = '0;
        xf_we        = 1'b0;
        xf_erase     = 1'b0;

        // Requests arriving while busy collapse into a single pending save.
        if (save_req && (state_q != IDLE)) pend_d = 1'b1;

        unique case (state_q)
            LOAD_REQ: begin
                xf_start = 1'b1;
                state_d  = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (xf_done) begin
                    pw_valid_d      = 1'b1;
                    pw_idx_d        = idx_q;
                    pw_data_d       = xf_rdat;
                    loaded_d[idx_q] = (xf_rdat != ERASED_WORD);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = LOAD_REQ;
                    end
                end else if (xf_retry) begin
                    state_d = LOAD_REQ;
                end else if (xf_fail) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            IDLE: begin
                if (save_req || pend_q) begin
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    state_d = SNAP;
                end
            end
            SNAP: begin
                preset_buf_d[idx_q] = rd_data;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ERASE_REQ;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ERASE_REQ: begin
                xf_start = 1'b1;
                xf_adr   = BASE_ADDR & SECTOR_MASK;
                xf_erase = 1'b1;
                state_d  = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                if (xf_done) begin
                    idx_d   = '0;
                    state_d = WR_REQ;
                end else if (xf_retry) begin
                    state_d = ERASE_REQ;
                end else if (xf_fail) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            WR_REQ: begin
                xf_start = 1'b1;
                xf_we    = 1'b1;
                xf_wdat  = preset_buf_q[idx_q];
                state_d  = WR_WAIT;
            end
            WR_WAIT: begin
                if (xf_done) begin
                    if (idx_q == LAST_IDX) begin
                        loaded_d = {preset_buf_q[3] != ERASED_WORD,
                                    preset_buf_q[2] != ERASED_WORD,
                                    preset_buf_q[1] != ERASED_WORD,
                                    preset_buf_q[0] != ERASED_WORD};
                        idx_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = WR_REQ;
                    end
                end else if (xf_retry) begin
                    state_d = WR_REQ;
                end else if (xf_fail) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end
            end
            FAIL: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LOAD_REQ;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            err_q        <= 1'b0;
            loaded_q     <= '0;
            pw_valid_q   <= 1'b0;
            pw_idx_q     <= '0;
            pw_data_q    <= '0;
            preset_buf_q <= '{default: '0};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
            loaded_q     <= loaded_d;
            pw_valid_q   <= pw_valid_d;
            pw_idx_q     <= pw_idx_d;
            pw_data_q    <= pw_data_d;
            preset_buf_q <= preset_buf_d;
        end
    end

    assign rd_idx   = (state_q == SNAP) ? idx_q : 2'd0;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign loaded   = loaded_q;
    assign pw_valid = pw_valid_q;
    assign pw_idx   = pw_idx_q;
    assign pw_data  = pw_data_q;

endmodule

// File: tb/tb_preset_store.sv
// Directed bench for preset_store: a responsive flash model with scripted retries,
// transaction/preset-word logs, and one task per scenario.
module tb_preset_store;

    localparam logic [23:0] BASE = 24'h1ffd80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        save_req = 1'b0;
    logic [1:0]  rd_idx;
    logic [31:0] rd_data;
    logic        pw_valid;
    logic [1:0]  pw_idx;
    logic [31:0] pw_data;
    logic [3:0]  loaded;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    preset_store_if bus ();

    logic [31:0] rd_tbl [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    assign rd_data = rd_tbl[rd_idx];

    preset_store #(
        .BASE_ADDR (24'h1ffd80),
        .RETRY_MAX (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .save_req (save_req),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .pw_valid (pw_valid),
        .pw_idx   (pw_idx),
        .pw_data  (pw_data),
        .loaded   (loaded),
        .busy     (busy),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Flash model: answers every strobe seen at a falling edge within that cycle.
    logic [31:0] mem [4] = '{32'hB02E7F1E, 32'hFFFFFFFF, 32'hC0420014, 32'hFFFFFFFF};
    logic [23:0] rty_addr  = 24'h0;
    int          rty_limit = 0;
    int          rty_given = 0;
    int          cyc = 0;
    logic [23:0] m_off;

    logic [23:0] l_adr [$];
    logic [31:0] l_dat [$];
    logic        l_we  [$];
    logic        l_er  [$];
    logic        l_rty [$];
    int          l_cyc [$];
    logic [1:0]  p_idx [$];
    logic [31:0] p_dat [$];

    initial begin
        bus.ack_i = 1'b0;
        bus.rty_i = 1'b0;
        bus.dat_i = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.ack_i = 1'b0;
            bus.rty_i = 1'b0;
            bus.dat_i = '0;
            if (bus.stb_o === 1'b1) begin
                l_adr.push_back(bus.adr_o);
                l_dat.push_back(bus.dat_o);
                l_we.push_back(bus.we_o);
                l_er.push_back(bus.erase_o);
                l_cyc.push_back(cyc);
                if (bus.adr_o == rty_addr && rty_given < rty_limit) begin
                    bus.rty_i = 1'b1;
                    rty_given++;
                    l_rty.push_back(1'b1);
                end else begin
                    bus.ack_i = 1'b1;
                    l_rty.push_back(1'b0);
                    m_off = bus.adr_o - BASE;
                    if (bus.erase_o) begin
                        for (int i = 0; i < 4; i++) mem[i] = 32'hFFFFFFFF;
                    end else if (m_off < 24'd16) begin
                        if (bus.we_o) mem[m_off[3:2]] = bus.dat_o;
                        else          bus.dat_i = mem[m_off[3:2]];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (pw_valid === 1'b1) begin
                p_idx.push_back(pw_idx);
                p_dat.push_back(pw_data);
            end
        end
    end

    task automatic wait_idle(input int max_cyc, input string name);
        bit done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1;
        end
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b required 0 within %0d cycles", name, busy, max_cyc);
        end
    endtask

    task automatic pulse_save();
        @(negedge clk) save_req = 1'b1;
        @(negedge clk) save_req = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.stb_o, bus.we_o, bus.erase_o, pw_valid, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: stb/we/erase/pw_valid/err=%b required 00000",
                     {bus.stb_o, bus.we_o, bus.erase_o, pw_valid, err});
        end
        checks++;
        if ({bus.adr_o, bus.dat_o, pw_data} !== 88'h0) begin
            errors++;
            $display("FAIL reset_data: adr=%h dat=%h pw_data=%h required 0", bus.adr_o, bus.dat_o, pw_data);
        end
        checks++;
        if (loaded !== 4'b0000 || busy !== 1'b1 || rd_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_status: loaded=%b busy=%b rd_idx=%0d required 0000 1 0", loaded, busy, rd_idx);
        end
    endtask

    task automatic test_load();
        logic [31:0] exp [4] = '{32'hB02E7F1E, 32'hFFFFFFFF, 32'hC0420014, 32'hFFFFFFFF};
        int lb = l_adr.size();
        int pb = p_idx.size();
        @(negedge clk) rst = 1'b1;
        wait_idle(100, "load");
        checks++;
        if (p_idx.size() != pb + 4) begin
            errors++;
            $display("FAIL load_pw_count: got %0d required 4", p_idx.size() - pb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (p_idx[pb+i] !== 2'(i) || p_dat[pb+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL load_pw[%0d]: idx=%0d data=%h required idx=%0d data=%h",
                             i, p_idx[pb+i], p_dat[pb+i], i, exp[i]);
                end
            end
        end
        checks++;
        if (l_adr.size() != lb + 4) begin
            errors++;
            $display("FAIL load_bus_count: got %0d required 4", l_adr.size() - lb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (l_adr[lb+i] !== BASE + 24'(4*i) || l_we[lb+i] !== 1'b0 || l_er[lb+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL load_bus[%0d]: adr=%h we=%b erase=%b required adr=%h we=0 erase=0",
                             i, l_adr[lb+i], l_we[lb+i], l_er[lb+i], BASE + 24'(4*i));
                end
            end
        end
        checks++;
        if (loaded !== 4'b0101 || err !== 1'b0) begin
            errors++;
            $display("FAIL load_flags: loaded=%b err=%b required 0101 0", loaded, err);
        end
    endtask

    task automatic test_load_retry();
        int lb;
        int n = 0;
        int last_cyc = 0;
        rty_addr  = 24'h1ffd84;
        rty_limit = rty_given + 2;
        @(negedge clk) rst = 1'b0;
        lb = l_adr.size();
        @(negedge clk) rst = 1'b1;
        wait_idle(100, "load_retry");
        checks++;
        if (l_adr.size() != lb + 6) begin
            errors++;
            $display("FAIL retry_bus_count: got %0d required 6", l_adr.size() - lb);
        end
        for (int i = lb; i < l_adr.size(); i++) begin
            if (l_adr[i] == 24'h1ffd84) begin
                checks++;
                if (l_rty[i] !== (n < 2) || (n > 0 && l_cyc[i] - last_cyc != 2)) begin
                    errors++;
                    $display("FAIL retry_attempt[%0d]: rty=%b gap=%0d required rty=%b gap=2",
                             n, l_rty[i], l_cyc[i] - last_cyc, n < 2);
                end
                last_cyc = l_cyc[i];
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL retry_attempts: got %0d strobes at 1ffd84 required 3", n);
        end
        checks++;
        if (err !== 1'b0 || loaded !== 4'b0101) begin
            errors++;
            $display("FAIL retry_flags: err=%b loaded=%b required 0 0101", err, loaded);
        end
    endtask

    task automatic test_save();
        int lb = l_adr.size();
        int pb = p_idx.size();
        rd_tbl = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        pulse_save();
        wait_idle(100, "save");
        checks++;
        if (l_adr.size() != lb + 5) begin
            errors++;
            $display("FAIL save_bus_count: got %0d required 5", l_adr.size() - lb);
        end else begin
            checks++;
            if (l_adr[lb] !== 24'h1ff000 || l_er[lb] !== 1'b1 || l_we[lb] !== 1'b0) begin
                errors++;
                $display("FAIL save_erase: adr=%h erase=%b we=%b required 1ff000 1 0", l_adr[lb], l_er[lb], l_we[lb]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (l_adr[lb+1+i] !== BASE + 24'(4*i) || l_we[lb+1+i] !== 1'b1 ||
                    l_er[lb+1+i] !== 1'b0 || l_dat[lb+1+i] !== rd_tbl[i]) begin
                    errors++;
                    $display("FAIL save_write[%0d]: adr=%h we=%b data=%h required adr=%h we=1 data=%h",
                             i, l_adr[lb+1+i], l_we[lb+1+i], l_dat[lb+1+i], BASE + 24'(4*i), rd_tbl[i]);
                end
            end
        end
        checks++;
        if (loaded !== 4'b1111 || err !== 1'b0 || p_idx.size() != pb) begin
            errors++;
            $display("FAIL save_flags: loaded=%b err=%b pw_pulses=%0d required 1111 0 0",
                     loaded, err, p_idx.size() - pb);
        end
    endtask

    task automatic test_erase_fail();
        int lb = l_adr.size();
        int n = 0;
        rty_addr  = 24'h1ff000;
        rty_limit = rty_given + 100;
        pulse_save();
        wait_idle(200, "erase_fail");
        for (int i = lb; i < l_adr.size(); i++)
            if (l_er[i] === 1'b1 && l_rty[i] === 1'b1) n++;
        checks++;
        if (n != 7 || l_adr.size() != lb + 7) begin
            errors++;
            $display("FAIL fail_attempts: rty_erase=%0d total=%0d required 7 7", n, l_adr.size() - lb);
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || loaded !== 4'b1111) begin
            errors++;
            $display("FAIL fail_flags: err=%b busy=%b loaded=%b required 1 0 1111", err, busy, loaded);
        end
        rty_limit = rty_given;
        lb = l_adr.size();
        pulse_save();
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fail_err_clear: err=%b busy=%b required 0 1", err, busy);
        end
        wait_idle(100, "resave");
        checks++;
        if (l_adr.size() != lb + 5 || err !== 1'b0 || loaded !== 4'b1111) begin
            errors++;
            $display("FAIL resave: bus=%0d err=%b loaded=%b required 5 0 1111", l_adr.size() - lb, err, loaded);
        end
    endtask

    task automatic test_pending();
        int lb;
        int pb = p_idx.size();
        rd_tbl = '{32'hA5A50000, 32'hFFFFFFFF, 32'h5A5A0002, 32'h12345678};
        @(negedge clk) rst = 1'b0;
        lb = l_adr.size();
        @(negedge clk) rst = 1'b1;
        pulse_save();
        @(negedge clk);
        pulse_save();
        repeat (80) @(negedge clk);
        #1;
        checks++;
        if (l_adr.size() != lb + 9) begin
            errors++;
            $display("FAIL pend_bus_count: got %0d required 9 (4 reads + 1 erase + 4 writes)", l_adr.size() - lb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (l_we[lb+i] !== 1'b0 || l_er[lb+i] !== 1'b0 || l_adr[lb+i] !== BASE + 24'(4*i)) begin
                    errors++;
                    $display("FAIL pend_read[%0d]: adr=%h we=%b required %h 0", i, l_adr[lb+i], l_we[lb+i], BASE + 24'(4*i));
                end
                checks++;
                if (l_we[lb+5+i] !== 1'b1 || l_dat[lb+5+i] !== rd_tbl[i]) begin
                    errors++;
                    $display("FAIL pend_write[%0d]: we=%b data=%h required 1 %h", i, l_we[lb+5+i], l_dat[lb+5+i], rd_tbl[i]);
                end
            end
            checks++;
            if (l_er[lb+4] !== 1'b1) begin
                errors++;
                $display("FAIL pend_erase: erase=%b required 1", l_er[lb+4]);
            end
        end
        checks++;
        if (p_idx.size() != pb + 4 || p_dat[pb+3] !== 32'h44444444) begin
            errors++;
            $display("FAIL pend_pw: pulses=%0d last=%h required 4 44444444", p_idx.size() - pb, p_dat[p_dat.size()-1]);
        end
        checks++;
        if (busy !== 1'b0 || loaded !== 4'b1101) begin
            errors++;
            $display("FAIL pend_flags: busy=%b loaded=%b required 0 1101", busy, loaded);
        end
    endtask

    task automatic test_reset_mid_write();
        // Flash was erased and words 0..2 acked before the reset hit, so word 3 stays erased.
        logic [31:0] exp [4] = '{32'h01010101, 32'hFFFFFFFF, 32'h03030303, 32'hFFFFFFFF};
        bit hit = 0;
        int lb;
        int pb;
        rd_tbl = '{32'h01010101, 32'hFFFFFFFF, 32'h03030303, 32'h04040404};
        pulse_save();
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (bus.stb_o === 1'b1 && bus.we_o === 1'b1 && bus.adr_o === 24'h1ffd88) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midwr_reach: write to 1ffd88 not seen within 100 cycles");
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.stb_o, bus.we_o, bus.erase_o, pw_valid, err} !== 5'b0 || {bus.adr_o, bus.dat_o, pw_data} !== 88'h0) begin
            errors++;
            $display("FAIL midwr_async: stb/we/erase/pw_valid/err=%b adr=%h dat=%h pw_data=%h required all 0",
                     {bus.stb_o, bus.we_o, bus.erase_o, pw_valid, err}, bus.adr_o, bus.dat_o, pw_data);
        end
        checks++;
        if (loaded !== 4'b0000 || busy !== 1'b1 || rd_idx !== 2'd0) begin
            errors++;
            $display("FAIL midwr_status: loaded=%b busy=%b rd_idx=%0d required 0000 1 0", loaded, busy, rd_idx);
        end
        lb = l_adr.size();
        pb = p_idx.size();
        @(negedge clk) rst = 1'b1;
        wait_idle(100, "midwr_reload");
        checks++;
        if (l_adr.size() != lb + 4 || p_idx.size() != pb + 4) begin
            errors++;
            $display("FAIL midwr_reload_count: bus=%0d pw=%0d required 4 4", l_adr.size() - lb, p_idx.size() - pb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (l_adr[lb+i] !== BASE + 24'(4*i) || l_we[lb+i] !== 1'b0 || p_dat[pb+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL midwr_reload[%0d]: adr=%h we=%b pw_data=%h required %h 0 %h",
                             i, l_adr[lb+i], l_we[lb+i], p_dat[pb+i], BASE + 24'(4*i), exp[i]);
                end
            end
        end
        checks++;
        if (loaded !== 4'b0101 || err !== 1'b0) begin
            errors++;
            $display("FAIL midwr_flags: loaded=%b err=%b required 0101 0", loaded, err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_retry();
        test_save();
        test_erase_fail();
        test_pending();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
